pushbutton_event_master: RTL and testbench
==========================================

PUSHBUTTON_EVENT_MASTER -- requirements
Module: pushbutton_event_master

Interface
REQ-001 SHALL have parameter IRQ_MASK, default 4'hF, meaning the interrupt-mask value written to the pushbutton PIO after reset.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 irq  input  1  interrupt from the pushbutton PIO (high while any masked edge-capture bit is set).
REQ-005 avm_address  output  2  PIO register select: 0 data, 2 irq mask, 3 edge capture.
REQ-006 avm_chipselect  output  1  PIO access strobe.
REQ-007 avm_write_n  output  1  active-low write strobe.
REQ-008 avm_writedata  output  32  write data.
REQ-009 avm_readdata  input  32  PIO read data, registered with fixed latency 1 (valid the cycle after the address is driven).
REQ-010 event_valid  output  1  a button-press event is pending.
REQ-011 event_data  output  4  one bit per button pressed since the last accepted event.
REQ-012 event_overflow  output  1  events were merged before the consumer accepted them.
REQ-013 event_ready  input  1  consumer accepts the event when event_valid and event_ready are both high.

Function
REQ-014 SHALL implement an Avalon-MM initiator FSM with states INIT, IDLE, READ, CAPTURE, CLEAR, registered outputs.
REQ-015 INIT: drive chipselect=1, write_n=0, address=2, writedata={28'b0,IRQ_MASK} for exactly one cycle; next state IDLE.
REQ-016 IDLE: chipselect=0, write_n=1, address=0, writedata=0; if irq=1 go to READ, else stay.
REQ-017 READ: chipselect=1, write_n=1, address=3, for one cycle; next CAPTURE.
REQ-018 CAPTURE: bus idle (as IDLE); sample avm_readdata[3:0] into cap_reg; if cap_reg value is 0 (spurious), return to IDLE without write or event; otherwise go to CLEAR.
REQ-019 CLEAR: chipselect=1, write_n=0, address=3, writedata={28'b0,cap_reg} for one cycle (write-1-to-clear exactly the captured bits); next IDLE.
REQ-020 Latency: irq first high in IDLE at cycle T -> READ at T+1, CAPTURE at T+2, CLEAR at T+3, event_valid high from T+4.
REQ-021 Event load at end of CLEAR: if event_valid=0, or event_valid=1 and event_ready=1 in that cycle, event_data <= cap_reg, event_overflow <= 0.
REQ-022 If event_valid=1 and event_ready=0 at end of CLEAR: event_data <= event_data | cap_reg, event_overflow <= 1 (sticky until acceptance).
REQ-023 Acceptance (valid & ready) with no simultaneous load: event_valid, event_data, event_overflow all clear next cycle.
REQ-024 event_data/event_overflow SHALL stay stable while event_valid=1 and not accepted, except for the merge in REQ-022.
REQ-025 Edges on bits not in cap_reg that arrive during servicing remain in the PIO; irq stays high and the FSM re-services from IDLE (irq sampled in IDLE only, one cycle after CLEAR).
REQ-026 An edge on a captured bit in the same cycle as its CLEAR write is lost (PIO clear has priority); this is accepted behaviour.
REQ-027 event_ready is ignored when event_valid=0.

Reset
REQ-028 reset_n low, at any time including mid-transaction: state=INIT, chipselect=0, write_n=1, address=0, writedata=0, cap_reg=0, event_valid=0, event_data=0, event_overflow=0.
REQ-029 First clock edge after reset_n deasserts SHALL enter INIT output cycle; mask write occurs once per reset release.

Verification
REQ-030 Reset release, irq=0 -> one cycle of write addr 2 data 0x0000000F, then bus idle indefinitely, event_valid=0.
REQ-031 PIO model edge_capture=4'b0100, irq=1 at T, event_ready=1 -> read addr 3 at T+1, write addr 3 data 0x4 at T+3, event_valid=1 event_data=4'h4 overflow=0 at T+4, cleared at T+5.
REQ-032 event_ready=0, two services capturing 4'h1 then 4'h8 -> event_data=4'h9, event_overflow=1; raise ready -> both clear next cycle.
REQ-033 irq pulse but readdata returns 0 at CAPTURE -> no write to addr 3, no event, FSM back to IDLE.
REQ-034 Edge on bit 2 arrives during CLEAR of bit 0 -> second service captures 4'h4 without irq deassert in between; event sequence 4'h1 then 4'h4 (ready=1).
REQ-035 reset_n asserted during READ -> all outputs to reset values asynchronously; after release, INIT mask write reissued and pending PIO irq serviced normally.

Source files
------------

// File: rtl/pushbutton_event_master.sv
// Avalon-MM initiator that services a pushbutton PIO: it arms the IRQ mask, reads and clears
// edge-capture bits, and presents the pressed buttons to a consumer as a valid/ready event.
module pushbutton_event_master #(
  parameter logic [3:0] IRQ_MASK = 4'hF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        irq,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  output logic        event_valid,
  output logic [3:0]  event_data,
  output logic        event_overflow,
  input  logic        event_ready
);

  localparam int unsigned BTN_W  = 4;
  localparam int unsigned DATA_W = 32;
  localparam logic [1:0]  ADDR_DATA = 2'd0;
  localparam logic [1:0]  ADDR_MASK = 2'd2;
  localparam logic [1:0]  ADDR_EDGE = 2'd3;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_CLEAR
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          avm_address_q, avm_address_d;
  logic                avm_chipselect_q, avm_chipselect_d;
  logic                avm_write_n_q, avm_write_n_d;
  logic [DATA_W-1:0]   avm_writedata_q, avm_writedata_d;
  logic [BTN_W-1:0]    cap_q, cap_d;
  logic                event_valid_q, event_valid_d;
  logic [BTN_W-1:0]    event_data_q, event_data_d;
  logic                event_overflow_q, event_overflow_d;

  // Only the button bits of the PIO data word are meaningful.
  logic unused_readdata;
  assign unused_readdata = ^avm_readdata[DATA_W-1:BTN_W];

  // Bus FSM: outputs are computed for the state being entered, so the bus lines up with state_q.
  always_comb begin
    state_d          = state_q;
    avm_chipselect_d = 1'b0;
    avm_write_n_d    = 1'b1;
    avm_address_d    = ADDR_DATA;
    avm_writedata_d  = '0;
    cap_d            = cap_q;

    case (state_q)
      S_INIT: begin
        // Reset leaves INIT with an idle bus; the mask write goes out on the first edge.
        if (!avm_chipselect_q) begin
          avm_chipselect_d = 1'b1;
          avm_write_n_d    = 1'b0;
          avm_address_d    = ADDR_MASK;
          avm_writedata_d  = {(DATA_W-BTN_W)'(0), IRQ_MASK};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (irq) begin
          state_d          = S_READ;
          avm_chipselect_d = 1'b1;
          avm_address_d    = ADDR_EDGE;
        end
      end
      S_READ: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        cap_d = avm_readdata[BTN_W-1:0];
        if (cap_d != '0) begin
          state_d          = S_CLEAR;
          avm_chipselect_d = 1'b1;
          avm_write_n_d    = 1'b0;
          avm_address_d    = ADDR_EDGE;
          avm_writedata_d  = {(DATA_W-BTN_W)'(0), cap_d};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // Event holding register: load or merge at the end of CLEAR, drop on acceptance.
  always_comb begin
    event_valid_d    = event_valid_q;
    event_data_d     = event_data_q;
    event_overflow_d = event_overflow_q;

    if (state_q == S_CLEAR) begin
      event_valid_d = 1'b1;
      if (!event_valid_q || event_ready) begin
        event_data_d     = cap_q;
        event_overflow_d = 1'b0;
      end else begin
        event_data_d     = event_data_q | cap_q;
        event_overflow_d = 1'b1;
      end
    end else if (event_valid_q && event_ready) begin
      event_valid_d    = 1'b0;
      event_data_d     = '0;
      event_overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_INIT;
      avm_chipselect_q <= 1'b0;
      avm_write_n_q    <= 1'b1;
      avm_address_q    <= ADDR_DATA;
      avm_writedata_q  <= '0;
      cap_q            <= '0;
      event_valid_q    <= 1'b0;
      event_data_q     <= '0;
      event_overflow_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      avm_chipselect_q <= avm_chipselect_d;
      avm_write_n_q    <= avm_write_n_d;
      avm_address_q    <= avm_address_d;
      avm_writedata_q  <= avm_writedata_d;
      cap_q            <= cap_d;
      event_valid_q    <= event_valid_d;
      event_data_q     <= event_data_d;
      event_overflow_q <= event_overflow_d;
    end
  end

  assign avm_chipselect = avm_chipselect_q;
  assign avm_write_n    = avm_write_n_q;
  assign avm_address    = avm_address_q;
  assign avm_writedata  = avm_writedata_q;
  assign event_valid    = event_valid_q;
  assign event_data     = event_data_q;
  assign event_overflow = event_overflow_q;

endmodule

// File: tb/tb_pushbutton_event_master.sv
// Bench for pushbutton_event_master: a PIO model drives irq/readdata, and a transaction-schedule
// reference predicts the bus activity and event outputs for every cycle.
module tb_pushbutton_event_master;

  localparam logic [3:0]  MASK = 4'hF;
  localparam int          BIG  = 32'h7fffffff;
  localparam logic [35:0] IDLE_BUS = {1'b0, 1'b1, 2'd0, 32'd0};
  localparam logic [35:0] RD_EDGE  = {1'b1, 1'b1, 2'd3, 32'd0};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        irq;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        event_valid;
  logic [3:0]  event_data;
  logic        event_overflow;
  logic        event_ready = 1'b0;

  always #5 clk = ~clk;

  pushbutton_event_master #(.IRQ_MASK(MASK)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .irq            (irq),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .event_valid    (event_valid),
    .event_data     (event_data),
    .event_overflow (event_overflow),
    .event_ready    (event_ready)
  );

  // PIO model: edge capture with write-1-to-clear (clear wins over a same-cycle edge).
  logic [3:0]  pio_edge  = 4'd0;
  logic [3:0]  pio_mask  = 4'd0;
  logic [31:0] pio_rdata = 32'd0;
  logic [3:0]  inject    = 4'd0;
  logic        irq_force = 1'b0;

  assign irq          = (|(pio_edge & pio_mask)) | irq_force;
  assign avm_readdata = pio_rdata;

  always @(posedge clk) begin
    logic [3:0] clr;
    clr = (avm_chipselect && !avm_write_n && avm_address == 2'd3) ? avm_writedata[3:0] : 4'd0;
    if (avm_chipselect && !avm_write_n && avm_address == 2'd2) pio_mask <= avm_writedata[3:0];
    pio_edge  <= (pio_edge | inject) & ~clr;
    pio_rdata <= (avm_chipselect && avm_write_n && avm_address == 2'd3) ? {28'd0, pio_edge} : 32'd0;
  end

  // Reference state: expected bus per cycle, service timeline, expected event register.
  logic [35:0] exp_bus [int];
  int          cyc     = 0;
  int          free_at = BIG;
  int          cap_at  = -1;
  int          load_at = -1;
  logic [3:0]  cap_v   = 4'd0;
  logic        ev_v    = 1'b0;
  logic        ev_o    = 1'b0;
  logic [3:0]  ev_d    = 4'd0;
  bit          rst_prev = 1'b0;
  logic [3:0]  acc_q [$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: compare outputs, drive inputs for the rest of the cycle, advance the model.
  task automatic step(input bit rst, input bit rdy, input logic [3:0] inj, input bit frc);
    logic [35:0] eb, db;
    logic [3:0]  v, nd;
    logic        nv, no, irq_now;
    @(negedge clk);
    eb = exp_bus.exists(cyc) ? exp_bus[cyc] : IDLE_BUS;
    if (exp_bus.exists(cyc)) exp_bus.delete(cyc);
    db = {avm_chipselect, avm_write_n, avm_address, avm_writedata};
    if (eb[35] && eb[34]) db[31:0] = 32'd0;
    check("bus", 64'(db), 64'(eb));
    check("event", 64'({event_valid, event_overflow, event_data}), 64'({ev_v, ev_o, ev_d}));
    if (event_valid && event_ready) acc_q.push_back(event_data);

    reset_n     = rst;
    event_ready = rdy;
    inject      = inj;
    irq_force   = frc;

    if (!rst) begin
      exp_bus.delete();
      free_at = BIG; cap_at = -1; load_at = -1;
      ev_v = 1'b0; ev_o = 1'b0; ev_d = 4'd0;
    end else begin
      if (!rst_prev) begin
        exp_bus[cyc+1] = {1'b1, 1'b0, 2'd2, {28'd0, MASK}};
        free_at = cyc + 2;
      end
      irq_now = (|(pio_edge & pio_mask)) | frc;
      nv = ev_v; no = ev_o; nd = ev_d;
      if (load_at == cyc) begin
        nv = 1'b1;
        if (!ev_v || rdy) begin nd = cap_v; no = 1'b0; end
        else begin nd = ev_d | cap_v; no = 1'b1; end
      end else if (ev_v && rdy) begin
        nv = 1'b0; no = 1'b0; nd = 4'd0;
      end
      ev_v = nv; ev_o = no; ev_d = nd;
      if (cap_at == cyc) begin
        v = pio_rdata[3:0];
        cap_at = -1;
        if (v != 4'd0) begin
          exp_bus[cyc+1] = {1'b1, 1'b0, 2'd3, {28'd0, v}};
          cap_v   = v;
          load_at = cyc + 1;
          free_at = cyc + 2;
        end else begin
          free_at = cyc + 1;
        end
      end else if (cyc >= free_at && irq_now) begin
        exp_bus[cyc+1] = RD_EDGE;
        cap_at  = cyc + 2;
        free_at = BIG;
      end
    end
    rst_prev = rst;
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit found;
    repeat (3) step(0, 0, 4'd0, 0);

    // Reset release: single mask write, then quiet bus.
    step(1, 0, 4'd0, 0);
    step(1, 0, 4'd0, 0);
    check("init_wr", 64'({avm_chipselect, avm_write_n, avm_address, avm_writedata}),
          64'({1'b1, 1'b0, 2'd2, 32'h0000000F}));
    repeat (10) step(1, 0, 4'd0, 0);
    check("no_event", 64'(event_valid), 64'd0);

    // Single press on bit 2 with consumer ready.
    acc_q.delete();
    step(1, 1, 4'b0100, 0);
    repeat (8) step(1, 1, 4'd0, 0);
    check("single_cnt", 64'(acc_q.size()), 64'd1);
    if (acc_q.size() > 0) check("single_data", 64'(acc_q[0]), 64'h4);
    check("single_edge_clr", 64'(pio_edge), 64'd0);

    // Two services while stalled merge into one overflowed event.
    step(1, 0, 4'b0001, 0);
    repeat (7) step(1, 0, 4'd0, 0);
    step(1, 0, 4'b1000, 0);
    repeat (7) step(1, 0, 4'd0, 0);
    check("merge", 64'({event_valid, event_overflow, event_data}), 64'({1'b1, 1'b1, 4'h9}));
    step(1, 1, 4'd0, 0);
    step(1, 0, 4'd0, 0);
    check("merge_clr", 64'({event_valid, event_overflow, event_data}), 64'd0);

    // Spurious irq: read returns zero, no clear write and no event.
    acc_q.delete();
    step(1, 1, 4'd0, 1);
    repeat (8) step(1, 1, 4'd0, 0);
    check("spur_none", 64'(acc_q.size()), 64'd0);
    check("spur_valid", 64'(event_valid), 64'd0);

    // Edge on bit 2 lands during the CLEAR of bit 0; irq never drops in between.
    acc_q.delete();
    step(1, 1, 4'b0001, 0);
    step(1, 1, 4'd0, 0);
    step(1, 1, 4'd0, 0);
    step(1, 1, 4'b0100, 0);
    step(1, 1, 4'd0, 0);
    check("irq_hold_clear", 64'(irq), 64'd1);
    step(1, 1, 4'd0, 0);
    check("irq_hold_idle", 64'(irq), 64'd1);
    repeat (10) step(1, 1, 4'd0, 0);
    check("seq_cnt", 64'(acc_q.size()), 64'd2);
    if (acc_q.size() == 2) begin
      check("seq_first", 64'(acc_q[0]), 64'h1);
      check("seq_second", 64'(acc_q[1]), 64'h4);
    end

    // Reset during READ, then the still-pending edge is serviced after re-init.
    acc_q.delete();
    step(1, 1, 4'b0010, 0);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (avm_chipselect && avm_write_n && avm_address == 2'd3) begin
        found = 1'b1;
        break;
      end
      step(1, 1, 4'd0, 0);
    end
    check("rd_seen", 64'(found), 64'd1);
    step(0, 1, 4'd0, 0);
    #1;
    check("async_rst", 64'({avm_chipselect, avm_write_n, avm_address, avm_writedata,
                            event_valid, event_overflow, event_data}),
          64'({IDLE_BUS, 6'd0}));
    step(0, 1, 4'd0, 0);
    step(1, 1, 4'd0, 0);
    repeat (12) step(1, 1, 4'd0, 0);
    check("rst_svc_cnt", 64'(acc_q.size()), 64'd1);
    if (acc_q.size() > 0) check("rst_svc_data", 64'(acc_q[0]), 64'h2);

    // Randomized traffic, backpressure, spurious irqs and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      bit         r, rdy, frc;
      logic [3:0] inj;
      r   = ($urandom_range(0, 599) != 0);
      inj = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'd0;
      rdy = 1'($urandom_range(0, 1));
      frc = ($urandom_range(0, 63) == 0);
      step(r, rdy, inj, frc);
    end
    repeat (10) step(1, 1, 4'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
